// File: rtl/clint_pkg.sv
// Shared definitions for the core-local trap sequencer: FSM states, CSR addresses,
// trap-related instruction encodings, cause codes and mstatus update helpers.
package clint_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MEPC         = 3'd1,
    MCAUSE       = 3'd2,
    MSTATUS      = 3'd3,
    MRET_MSTATUS = 3'd4,
    ASSERT       = 3'd5
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Trap entry: save MIE into MPIE, then disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // MRET: restore MIE from MPIE, then set MPIE.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_trap.sv
// Core-local trap sequencer: detects ECALL/EBREAK/MRET and interrupts, stalls the
// pipeline, writes mepc/mcause/mstatus, then redirects execute with a one-cycle pulse.
//
// state        | meaning
// IDLE         | combinational detect; hold raised in the detect cycle
// MEPC         | write return PC to mepc
// MCAUSE       | write cause to mcause
// MSTATUS      | trap entry mstatus write (MPIE<=MIE, MIE<=0)
// MRET_MSTATUS | MRET mstatus write (MIE<=MPIE, MPIE<=1)
// ASSERT       | redirect pulse to mtvec (trap) or mepc (MRET)
module clint_trap
  import clint_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ext_hold_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [ADDR_W-1:0] csr_mtvec_i,
  input  logic [ADDR_W-1:0] csr_mepc_i,
  input  logic [31:0]       csr_mstatus_i,
  output logic              hold_flag_o,
  output logic              we_o,
  output logic [11:0]       waddr_o,
  output logic [31:0]       wdata_o,
  output logic              int_assert_o,
  output logic [ADDR_W-1:0] int_addr_o
);

  state_e            r_state;
  state_e            w_next_state;
  logic [31:0]       r_cause;
  logic [31:0]       r_mstatus;
  logic [ADDR_W-1:0] r_ret_pc;
  logic              r_is_mret;

  logic              w_sync;
  logic              w_mret;
  logic              w_async;
  logic              w_load;
  logic              w_take_mret;
  logic [31:0]       w_cause;
  logic [ADDR_W-1:0] w_ret_pc;

  always_comb begin
    w_sync       = 1'b0;
    w_mret       = 1'b0;
    w_async      = 1'b0;
    w_load       = 1'b0;
    w_take_mret  = 1'b0;
    w_cause      = 32'd0;
    w_ret_pc     = inst_addr_i;
    w_next_state = r_state;
    hold_flag_o  = 1'b0;
    we_o         = 1'b0;
    waddr_o      = 12'd0;
    wdata_o      = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    // Detection is masked while reset is active so every output reads 0 in reset.
    w_sync  = rst_n_i && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
    w_mret  = rst_n_i && (inst_i == INST_MRET);
    w_async = rst_n_i && (|int_flag_i) && csr_mstatus_i[MSTATUS_MIE] && !ext_hold_i;

    if (w_sync) begin
      w_cause = (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
    end else begin
      w_cause = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
    end
    // An async trap must resume at the jump target if execute is redirecting now.
    if (!w_sync && jump_flag_i) begin
      w_ret_pc = jump_addr_i;
    end

    case (r_state)
      IDLE: begin
        if (w_sync || w_async) begin
          w_next_state = MEPC;
          w_load       = 1'b1;
          hold_flag_o  = 1'b1;
        end else if (w_mret) begin
          w_next_state = MRET_MSTATUS;
          w_load       = 1'b1;
          w_take_mret  = 1'b1;
          hold_flag_o  = 1'b1;
        end
      end
      MEPC: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_MEPC;
        wdata_o      = 32'(r_ret_pc);
        w_next_state = MCAUSE;
      end
      MCAUSE: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_MCAUSE;
        wdata_o      = r_cause;
        w_next_state = MSTATUS;
      end
      MSTATUS: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_MSTATUS;
        wdata_o      = mstatus_on_trap(r_mstatus);
        w_next_state = ASSERT;
      end
      MRET_MSTATUS: begin
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_MSTATUS;
        wdata_o      = mstatus_on_mret(r_mstatus);
        w_next_state = ASSERT;
      end
      ASSERT: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = r_is_mret ? csr_mepc_i : csr_mtvec_i;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_cause   <= 32'd0;
      r_mstatus <= 32'd0;
      r_ret_pc  <= '0;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_cause   <= w_cause;
        r_mstatus <= csr_mstatus_i;
        r_ret_pc  <= w_ret_pc;
        r_is_mret <= w_take_mret;
      end
    end
  end

endmodule

// File: tb/tb_clint_trap.sv
// Self-checking bench for clint_trap: a vector table expanded into per-cycle
// expectations through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_clint_trap;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ext_hold_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;
  logic        hold_flag_o;
  logic        we_o;
  logic [11:0] waddr_o;
  logic [31:0] wdata_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  always #5 clk_i = ~clk_i;

  clint_trap #(.INT_W(8), .ADDR_W(32)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .ext_hold_i   (ext_hold_i),
    .int_flag_i   (int_flag_i),
    .csr_mtvec_i  (csr_mtvec_i),
    .csr_mepc_i   (csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o  (hold_flag_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .int_assert_o (int_assert_o),
    .int_addr_o   (int_addr_o)
  );

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        ast;
    logic [31:0] addr;
  } obs_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] ia;
    logic        jf;
    logic [31:0] ja;
    logic        eh;
    logic [7:0]  intf;
    logic [31:0] ms;
    logic [31:0] mtvec;
    logic [31:0] mepc;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic obs_t mk(logic h, logic w, logic [11:0] a, logic [31:0] d,
                              logic s, logic [31:0] ad);
    obs_t o;
    o = '{hold: h, we: w, waddr: a, wdata: d, ast: s, addr: ad};
    return o;
  endfunction

  function automatic vec_t mkv(logic [31:0] inst, logic [31:0] ia, logic jf, logic [31:0] ja,
                               logic eh, logic [7:0] intf, logic [31:0] ms,
                               logic [31:0] mtvec, logic [31:0] mepc);
    vec_t v;
    v = '{inst: inst, ia: ia, jf: jf, ja: ja, eh: eh, intf: intf, ms: ms,
          mtvec: mtvec, mepc: mepc};
    return v;
  endfunction

  task automatic check(string name, obs_t exp);
    obs_t act;
    act = {hold_flag_o, we_o, waddr_o, wdata_o, int_assert_o, int_addr_o};
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got hold=%0b we=%0b waddr=%h wdata=%h assert=%0b addr=%h; want hold=%0b we=%0b waddr=%h wdata=%h assert=%0b addr=%h",
               name, act.hold, act.we, act.waddr, act.wdata, act.ast, act.addr,
               exp.hold, exp.we, exp.waddr, exp.wdata, exp.ast, exp.addr);
    end
  endtask

  task automatic step(string name, obs_t exp);
    @(negedge clk_i);
    check(name, exp);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(vec_t v);
    inst_i        = v.inst;
    inst_addr_i   = v.ia;
    jump_flag_i   = v.jf;
    jump_addr_i   = v.ja;
    ext_hold_i    = v.eh;
    int_flag_i    = v.intf;
    csr_mstatus_i = v.ms;
    csr_mtvec_i   = v.mtvec;
    csr_mepc_i    = v.mepc;
  endtask

  task automatic go_idle();
    inst_i      = NOP;
    jump_flag_i = 1'b0;
    ext_hold_i  = 1'b0;
    int_flag_i  = 8'h00;
  endtask

  // Expected per-cycle outputs from the detect cycle until the FSM is back in IDLE.
  function automatic void model(vec_t v);
    logic        sync, mret, async_i;
    logic [31:0] cause, ret, msw;
    obs_t        z;
    z       = mk(0, 0, 12'h0, 32'h0, 0, 32'h0);
    sync    = (v.inst == ECALL) || (v.inst == EBREAK);
    mret    = (v.inst == MRET);
    async_i = (v.intf != 8'h00) && v.ms[3] && !v.eh;
    if (sync || async_i) begin
      if (sync) cause = (v.inst == ECALL) ? 32'd11 : 32'd3;
      else      cause = v.intf[0] ? 32'h8000_0007 : 32'h8000_000B;
      ret    = (!sync && v.jf) ? v.ja : v.ia;
      msw    = v.ms;
      msw[7] = v.ms[3];
      msw[3] = 1'b0;
      sb.push_back(mk(1, 0, 12'h0,   32'h0, 0, 32'h0));
      sb.push_back(mk(1, 1, 12'h341, ret,   0, 32'h0));
      sb.push_back(mk(1, 1, 12'h342, cause, 0, 32'h0));
      sb.push_back(mk(1, 1, 12'h300, msw,   0, 32'h0));
      sb.push_back(mk(1, 0, 12'h0,   32'h0, 1, v.mtvec));
      sb.push_back(z);
    end else if (mret) begin
      msw    = v.ms;
      msw[3] = v.ms[7];
      msw[7] = 1'b1;
      sb.push_back(mk(1, 0, 12'h0,   32'h0, 0, 32'h0));
      sb.push_back(mk(1, 1, 12'h300, msw,   0, 32'h0));
      sb.push_back(mk(1, 0, 12'h0,   32'h0, 1, v.mepc));
      sb.push_back(z);
    end else begin
      sb.push_back(z);
    end
  endfunction

  task automatic run_vec(int idx);
    obs_t exp;
    int   k;
    drive(vecs[idx]);
    model(vecs[idx]);
    k = 0;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      @(negedge clk_i);
      check($sformatf("vec%0d_cyc%0d", idx, k), exp);
      @(posedge clk_i);
      #1;
      if (k == 0) go_idle();
      k++;
    end
  endtask

  obs_t z0;

  initial begin
    z0 = mk(0, 0, 12'h0, 32'h0, 0, 32'h0);
    vecs[0]  = mkv(ECALL,  32'h100,       0, 32'h0,         0, 8'h00, 32'h88,        32'h200,       32'h0);
    vecs[1]  = mkv(NOP,    32'h120,       1, 32'h400,       0, 8'h01, 32'h08,        32'h200,       32'h0);
    vecs[2]  = mkv(MRET,   32'h130,       0, 32'h0,         0, 8'h00, 32'h80,        32'h200,       32'h104);
    vecs[3]  = mkv(NOP,    32'h140,       0, 32'h0,         0, 8'h04, 32'h00,        32'h200,       32'h0);
    vecs[4]  = mkv(NOP,    32'h144,       0, 32'h0,         1, 8'h04, 32'h08,        32'h200,       32'h0);
    vecs[5]  = mkv(NOP,    32'h148,       0, 32'h0,         0, 8'h04, 32'h08,        32'h200,       32'h0);
    vecs[6]  = mkv(EBREAK, 32'h300,       1, 32'h900,       0, 8'h00, 32'h08,        32'h240,       32'h0);
    vecs[7]  = mkv(ECALL,  32'h310,       0, 32'h0,         0, 8'h01, 32'h08,        32'h240,       32'h0);
    vecs[8]  = mkv(ECALL,  32'hFFFF_FFFC, 0, 32'h0,         0, 8'h00, 32'hFFFF_FFFF, 32'hDEAD_BEE0, 32'h0);
    vecs[9]  = mkv(MRET,   32'h320,       0, 32'h0,         1, 8'h00, 32'h00,        32'h200,       32'h8000_0004);
    vecs[10] = mkv(MRET,   32'h330,       0, 32'h0,         0, 8'h01, 32'h88,        32'h200,       32'h1234_5678);
    vecs[11] = mkv(NOP,    32'h340,       1, 32'h8765_4320, 0, 8'h82, 32'h08,        32'h200,       32'h0);

    rst_n_i       = 1'b0;
    inst_i        = NOP;
    inst_addr_i   = 32'h0;
    jump_flag_i   = 1'b0;
    jump_addr_i   = 32'h0;
    ext_hold_i    = 1'b0;
    int_flag_i    = 8'h00;
    csr_mtvec_i   = 32'h0;
    csr_mepc_i    = 32'h0;
    csr_mstatus_i = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_state", z0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // ECALL beats a simultaneous timer interrupt; the interrupt waits for MIE re-enable.
    drive(mkv(ECALL, 32'h500, 0, 32'h0, 0, 8'h01, 32'h08, 32'h200, 32'h0));
    step("prio_d", mk(1, 0, 12'h0, 32'h0, 0, 32'h0));
    inst_i = NOP;
    step("prio_mepc",    mk(1, 1, 12'h341, 32'h500, 0, 32'h0));
    step("prio_mcause",  mk(1, 1, 12'h342, 32'd11,  0, 32'h0));
    step("prio_mstatus", mk(1, 1, 12'h300, 32'h80,  0, 32'h0));
    csr_mstatus_i = 32'h80;
    step("prio_assert",  mk(1, 0, 12'h0, 32'h0, 1, 32'h200));
    step("prio_masked0", z0);
    step("prio_masked1", z0);
    csr_mstatus_i = 32'h88;
    inst_addr_i   = 32'h504;
    step("pend_d",      mk(1, 0, 12'h0, 32'h0, 0, 32'h0));
    step("pend_mepc",   mk(1, 1, 12'h341, 32'h504, 0, 32'h0));
    step("pend_mcause", mk(1, 1, 12'h342, 32'h8000_0007, 0, 32'h0));
    int_flag_i = 8'h00;
    step("pend_mstatus", mk(1, 1, 12'h300, 32'h80, 0, 32'h0));
    csr_mstatus_i = 32'h80;
    step("pend_assert", mk(1, 0, 12'h0, 32'h0, 1, 32'h200));
    step("pend_idle", z0);

    // Reset asserted at D+2 of a trap entry drops the remaining writes.
    drive(mkv(ECALL, 32'h600, 0, 32'h0, 0, 8'h00, 32'h08, 32'h280, 32'h0));
    step("rst_d", mk(1, 0, 12'h0, 32'h0, 0, 32'h0));
    inst_i = NOP;
    step("rst_mepc", mk(1, 1, 12'h341, 32'h600, 0, 32'h0));
    #1;
    rst_n_i = 1'b0;
    #1;
    check("rst_async", z0);
    step("rst_hold0", z0);
    step("rst_hold1", z0);
    rst_n_i = 1'b1;
    step("rst_released", z0);
    step("rst_no_mstatus", z0);
    inst_i      = EBREAK;
    inst_addr_i = 32'h700;
    step("post_rst_d", mk(1, 0, 12'h0, 32'h0, 0, 32'h0));
    inst_i = NOP;
    step("post_rst_mepc",    mk(1, 1, 12'h341, 32'h700, 0, 32'h0));
    step("post_rst_mcause",  mk(1, 1, 12'h342, 32'd3,   0, 32'h0));
    step("post_rst_mstatus", mk(1, 1, 12'h300, 32'h80,  0, 32'h0));
    csr_mstatus_i = 32'h80;
    step("post_rst_assert",  mk(1, 0, 12'h0, 32'h0, 1, 32'h280));
    step("post_rst_idle",    z0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
